// File: rtl/uart_rx_gen.sv
// UART receiver: 2-flop synchronized rx, start/data/parity/stop framing, one-word holding register.
// Latency: word completes on the final stop sample; valid is asserted the following cycle.
// Backpressure: valid/ready handshake; a word completing while the held word is unread is dropped and overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: each sample is the 2-of-3 majority of the last three rxs values.
module uart_rx_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_acc;
  logic                 ferr_acc;
  logic                 sync_q;
  logic                 rxs;
  logic                 sample;
  logic                 word_done;
  logic                 word_ferr;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rx;
      rxs    <= sync_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1;
  logic rxs_d2;

  // History of the two previous synchronized values for the majority vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign sample = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign sample = rxs;
`endif

  // The final stop sample completes the word; its frame flag includes that last sample.
  assign word_done = (state == STOP) && (cnt == CNT_LAST) && (idx == IDX_LAST_STOP);
  assign word_ferr = ferr_acc | ~sample;

  // Framing FSM plus holding register; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      valid      <= 1'b0;
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // A completing word replaces the held one only if the slot is free or being read now.
      if (word_done) begin
        if (!valid || ready) begin
          dout       <= shift;
          parity_err <= perr_acc;
          frame_err  <= word_ferr;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            cnt      <= '0;
            idx      <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= sample ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= sample;
            if (idx == IDX_LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            perr_acc <= ((^shift) ^ sample) != (PARITY_MODE == 2);
            state    <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            ferr_acc <= word_ferr;
            if (idx == IDX_LAST_STOP) begin
              idx   <= '0;
              state <= sample ? IDLE : WAIT_HIGH;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Bench for uart_rx_gen: default 8N1 instance plus even/odd parity instances with two stop bits.
// Expected words come from a frame-level scoreboard filled by the stimulus driver.
module tb_uart_rx_gen;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic ready0 = 1'b1;
  logic rnd_ready = 1'b0;

  logic       valid0, perr0, ferr0, ovr0;
  logic [7:0] dout0;
  logic       valid_e, perr_e, ferr_e, ovr_e;
  logic [7:0] dout_e;
  logic       valid_o, perr_o, ferr_o, ovr_o;
  logic [7:0] dout_o;

  uart_rx_gen dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .ready(ready0), .valid(valid0), .dout(dout0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0)
  );
  uart_rx_gen #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst(rst), .rx(rx1), .ready(1'b1), .valid(valid_e), .dout(dout_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e)
  );
  uart_rx_gen #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst(rst), .rx(rx1), .ready(1'b1), .valid(valid_o), .dout(dout_o),
    .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } word_t;

  word_t q0[$];
  word_t qe[$];
  word_t qo[$];

  int checks = 0;
  int failures = 0;
  int vcyc0 = 0;
  int ovr_seen0 = 0;
  int exp_ovr0 = 0;
  int ovr_seen_p = 0;
  logic [7:0] last_d0 = 8'h00;
  logic       last_f0 = 1'b0;
  logic       last_pe = 1'b0;
  logic       last_po = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One step: inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rnd_ready) ready0 = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive(input int l, input logic v);
    if (l == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send_frame(input int l, input logic [7:0] d, input bit has_par,
                            input logic par, input int nstop, input logic [1:0] stops);
    drive(l, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(l, d[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive(l, par);
      tick(CPB);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(l, stops[s]);
      tick(CPB);
    end
  endtask

  task automatic expect0(input logic [7:0] d, input logic f);
    word_t w;
    w.d = d;
    w.p = 1'b0;
    w.f = f;
    q0.push_back(w);
  endtask

  // Parity rule stated as a ones count: even mode wants an even total, odd mode an odd total.
  task automatic expect_par(input logic [7:0] d, input logic par, input logic [1:0] stops);
    word_t we;
    word_t wo;
    int ones;
    ones = $countones(d) + int'(par);
    we.d = d;
    wo.d = d;
    we.p = (ones % 2) != 0;
    wo.p = (ones % 2) != 1;
    we.f = (stops != 2'b11);
    wo.f = (stops != 2'b11);
    qe.push_back(we);
    qo.push_back(wo);
  endtask

  // Per-cycle compare of every DUT's outputs against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr0) ovr_seen0++;
      if (ovr_e || ovr_o) ovr_seen_p++;
      if (valid0) begin
        vcyc0++;
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid0 actual dout=%0h required=no word", dout0);
        end else begin
          chk("dout0", 32'(dout0), 32'(q0[0].d));
          chk("perr0", 32'(perr0), 32'(q0[0].p));
          chk("ferr0", 32'(ferr0), 32'(q0[0].f));
          if (ready0) begin
            last_d0 = dout0;
            last_f0 = ferr0;
            q0.delete(0);
          end
        end
      end
      if (valid_e) begin
        if (qe.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_e actual dout=%0h required=no word", dout_e);
        end else begin
          chk("dout_e", 32'(dout_e), 32'(qe[0].d));
          chk("perr_e", 32'(perr_e), 32'(qe[0].p));
          chk("ferr_e", 32'(ferr_e), 32'(qe[0].f));
          last_pe = perr_e;
          qe.delete(0);
        end
      end
      if (valid_o) begin
        if (qo.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_o actual dout=%0h required=no word", dout_o);
        end else begin
          chk("dout_o", 32'(dout_o), 32'(qo[0].d));
          chk("perr_o", 32'(perr_o), 32'(qo[0].p));
          chk("ferr_o", 32'(ferr_o), 32'(qo[0].f));
          last_po = perr_o;
          qo.delete(0);
        end
      end
    end
  end

  initial begin
    int base;
    logic [7:0] d;
    logic par;
    logic [1:0] stops;

    tick(3);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_perr", 32'(perr0), 0);
    chk("rst_ferr", 32'(ferr0), 0);
    chk("rst_ovr", 32'(ovr0), 0);
    chk("rst_valid_e", 32'(valid_e), 0);
    rst = 1'b0;
    tick(2 * CPB);

    // Clean 0xA5 frame, consumer always ready: exactly one valid cycle.
    base = vcyc0;
    expect0(8'hA5, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(2 * CPB);
    chk("a5_valid_cycles", 32'(vcyc0 - base), 1);
    chk("a5_dout", 32'(last_d0), 32'h A5);
    chk("a5_ferr", 32'(last_f0), 0);

    // Glitch shorter than half a bit is a false start; then 0x3C.
    base = vcyc0;
    drive(0, 1'b0);
    tick(4);
    drive(0, 1'b1);
    tick(3 * CPB);
    chk("false_start_valid", 32'(vcyc0 - base), 0);
    expect0(8'h3C, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(2 * CPB);
    chk("after_false_dout", 32'(last_d0), 32'h3C);

    // 0x01 with parity bit 0: even mode flags it, odd mode accepts it.
    expect_par(8'h01, 1'b0, 2'b11);
    send_frame(1, 8'h01, 1'b1, 1'b0, 2, 2'b11);
    drive(1, 1'b1);
    tick(2 * CPB);
    chk("even_perr", 32'(last_pe), 1);
    chk("odd_perr", 32'(last_po), 0);

    // Low stop bit followed by a long break: one word with frame_err, no retrigger.
    base = vcyc0;
    expect0(8'h55, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b00);
    tick(40 * CPB);
    chk("break_valid_cycles", 32'(vcyc0 - base), 1);
    chk("break_ferr", 32'(last_f0), 1);
    drive(0, 1'b1);
    tick(2 * CPB);
    chk("after_break_valid", 32'(vcyc0 - base), 1);

    // Consumer stalled: 0x22 is dropped, 0x11 held, one overrun pulse.
    ready0 = 1'b0;
    expect0(8'h11, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(CPB);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(2 * CPB);
    exp_ovr0++;
    chk("ovr_hold_dout", 32'(dout0), 32'h11);
    chk("ovr_hold_valid", 32'(valid0), 1);
    chk("ovr_count", 32'(ovr_seen0), 32'(exp_ovr0));
    ready0 = 1'b1;
    tick(2);
    ready0 = 1'b0;

    // Read of 0x11 on the exact completion cycle of 0x22: 0x22 replaces it, no overrun.
    expect0(8'h11, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(CPB);
    expect0(8'h22, 1'b0);
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
      begin
        tick(154);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
      end
    join
    drive(0, 1'b1);
    tick(CPB);
    chk("same_cycle_dout", 32'(dout0), 32'h22);
    chk("same_cycle_valid", 32'(valid0), 1);
    chk("same_cycle_prev", 32'(last_d0), 32'h11);
    chk("same_cycle_ovr", 32'(ovr_seen0), 32'(exp_ovr0));
    ready0 = 1'b1;
    tick(2);

    // Reset in the middle of data bit 3 of 0xFF abandons the frame.
    base = vcyc0;
    drive(0, 1'b0);
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1);
      tick(CPB);
    end
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 32'(valid0), 0);
    chk("midrst_dout", 32'(dout0), 0);
    chk("midrst_ferr", 32'(ferr0), 0);
    chk("midrst_ovr", 32'(ovr0), 0);
    tick(3);
    rst = 1'b0;
    tick(8 * CPB);
    chk("midrst_no_valid", 32'(vcyc0 - base), 0);
    expect0(8'h81, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b11);
    drive(0, 1'b1);
    tick(2 * CPB);
    chk("after_rst_dout", 32'(last_d0), 32'h81);

    // Random words on the 8N1 instance with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      expect0(d, 1'b0);
      send_frame(0, d, 1'b0, 1'b0, 1, 2'b11);
      drive(0, 1'b1);
      tick($urandom_range(1, 3) * CPB);
    end
    rnd_ready = 1'b0;
    ready0 = 1'b1;

    // Random words, parity bits and occasional low stop bits on the parity instances.
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      expect_par(d, par, stops);
      send_frame(1, d, 1'b1, par, 2, stops);
      drive(1, 1'b1);
      tick($urandom_range(1, 3) * CPB);
    end

    for (int i = 0; i < 400 && (q0.size() + qe.size() + qo.size()) != 0; i++) tick(1);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("qe_drained", 32'(qe.size()), 0);
    chk("qo_drained", 32'(qo.size()), 0);
    chk("overrun_total", 32'(ovr_seen0), 32'(exp_ovr0));
    chk("par_overrun", 32'(ovr_seen_p), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
